circuit_vector_checker: RTL and testbench



---
 rtl/circuit_vector_checker_if.sv | 37 +++
 rtl/circuit_vector_checker.sv | 112 +++++++++++
 tb/tb_circuit_vector_checker.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/circuit_vector_checker_if.sv
// Bundle between the vector checker and the lab circuit it exercises.
// The checker drives vec_out and the result flags; the circuit side returns dut_y, the run controller drives start.
interface circuit_vector_checker_if;
    logic       start;
    logic       dut_y;
    logic [3:0] vec_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] err_count;
    logic       fail_valid;
    logic [3:0] first_fail;

    modport master (
        input  start,
        input  dut_y,
        output vec_out,
        output busy,
        output done,
        output pass,
        output err_count,
        output fail_valid,
        output first_fail
    );

    modport slave (
        output start,
        output dut_y,
        input  vec_out,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  fail_valid,
        input  first_fail
    );
endinterface

// File: rtl/circuit_vector_checker.sv
// Walks all 16 {A,B,C,D} input vectors, lets each settle, samples Y and
// compares it with EXP_TABLE, reporting pass, mismatch count and first failing index.
module circuit_vector_checker #(
    parameter logic [15:0] EXP_TABLE  = 16'hFFFF,
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    circuit_vector_checker_if.master   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

    state_t     state_q;
    logic [3:0] settle_cnt_q;
    logic [3:0] vec_q;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;
    logic [4:0] err_count_q;
    logic       fail_valid_q;
    logic [3:0] first_fail_q;

    logic       mismatch;
    logic [4:0] err_count_d;

    // err_count_d already includes the current sample so the final vector counts toward pass.
    assign mismatch    = (bus.dut_y != EXP_TABLE[vec_q]);
    assign err_count_d = err_count_q + {4'd0, mismatch};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            settle_cnt_q <= 4'd0;
            vec_q        <= 4'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_count_q  <= 5'd0;
            fail_valid_q <= 1'b0;
            first_fail_q <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        vec_q        <= 4'd0;
                        err_count_q  <= 5'd0;
                        fail_valid_q <= 1'b0;
                        first_fail_q <= 4'd0;
                        pass_q       <= 1'b0;
                        settle_cnt_q <= 4'd0;
                        busy_q       <= 1'b1;
                        state_q      <= SETTLE;
                    end
                end

                SETTLE: begin
                    settle_cnt_q <= settle_cnt_q + 4'd1;
                    if (settle_cnt_q == SETTLE_LAST) begin
                        state_q <= SAMPLE;
                    end
                end

                SAMPLE: begin
                    err_count_q <= err_count_d;
                    if (mismatch && !fail_valid_q) begin
                        first_fail_q <= vec_q;
                        fail_valid_q <= 1'b1;
                    end
                    if (vec_q == 4'd15) begin
                        // done and pass rise together on entry to DONE.
                        done_q  <= 1'b1;
                        pass_q  <= (err_count_d == 5'd0);
                        state_q <= DONE;
                    end else begin
                        vec_q        <= vec_q + 4'd1;
                        settle_cnt_q <= 4'd0;
                        state_q      <= SETTLE;
                    end
                end

                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    vec_q   <= 4'd0;
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.vec_out    = vec_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.err_count  = err_count_q;
    assign bus.fail_valid = fail_valid_q;
    assign bus.first_fail = first_fail_q;

endmodule

// File: tb/tb_circuit_vector_checker.sv
// Randomised self-checking bench for circuit_vector_checker: fault masks on dut_y
// are scored against counts derived directly from the mask.
module tb_circuit_vector_checker;

    localparam logic [15:0] EXP = 16'hFFFF;
    localparam int          PER_VEC = 3;   // SETTLE_CYC + 1
    localparam int          LATENCY = 48;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    circuit_vector_checker_if bus ();

    circuit_vector_checker #(
        .EXP_TABLE  (EXP),
        .SETTLE_CYC (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_vec"},   32'(bus.vec_out),    32'd0);
        check({tag, "_busy"},  32'(bus.busy),       32'd0);
        check({tag, "_done"},  32'(bus.done),       32'd0);
        check({tag, "_pass"},  32'(bus.pass),       32'd0);
        check({tag, "_err"},   32'(bus.err_count),  32'd0);
        check({tag, "_fv"},    32'(bus.fail_valid), 32'd0);
        check({tag, "_ff"},    32'(bus.first_fail), 32'd0);
    endtask

    // Expected Y driven in the sample window of vector i.
    function automatic logic y_for(input logic [15:0] mask, input int i);
        logic [15:0] e;
        e = EXP;
        return e[i] ^ mask[i];
    endfunction

    function automatic int lowest_bit(input logic [15:0] mask);
        for (int i = 0; i < 16; i++) if (mask[i]) return i;
        return 0;
    endfunction

    // One full run; pulse_at re-asserts start mid-run, reset_at aborts the run with rst_n.
    task automatic do_run(input logic [15:0] mask, input int pulse_at, input int reset_at, input string tag);
        int done_at;
        int vec_bad;
        int exp_err;
        bit aborted;
        done_at = -1;
        vec_bad = 0;
        aborted = 0;
        exp_err = $countones(mask);
        @(negedge clk);
        bus.start = 1'b1;
        bus.dut_y = 1'($urandom);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (k < LATENCY && int'(bus.vec_out) != k / PER_VEC) vec_bad++;
            if (k < LATENCY && bus.busy !== 1'b1) vec_bad++;
            if (bus.done === 1'b1) begin
                done_at = k;
                break;
            end
            if (k == reset_at) begin
                check({tag, "_pre_vec"}, 32'(bus.vec_out),   32'd7);
                check({tag, "_pre_err"}, 32'(bus.err_count), 32'd1);
                #2 rst_n = 1'b0;
                #1 check_all_zero({tag, "_async"});
                @(negedge clk);
                rst_n = 1'b1;
                aborted = 1;
                break;
            end
            bus.start = (k == pulse_at);
            if (k < LATENCY && (k % PER_VEC) == PER_VEC - 1)
                bus.dut_y = y_for(mask, k / PER_VEC);
            else
                bus.dut_y = 1'($urandom);
            @(negedge clk);
        end
        bus.start = 1'b0;
        if (!aborted) begin
            check({tag, "_latency"}, 32'(done_at), 32'(LATENCY));
            check({tag, "_vecseq"},  32'(vec_bad), 32'd0);
            check({tag, "_endvec"},  32'(bus.vec_out), 32'd15);
            check({tag, "_err"},     32'(bus.err_count), 32'(exp_err));
            check({tag, "_pass"},    32'(bus.pass), 32'(mask == 16'd0));
            check({tag, "_fv"},      32'(bus.fail_valid), 32'(mask != 16'd0));
            if (mask != 16'd0)
                check({tag, "_ff"},  32'(bus.first_fail), 32'(lowest_bit(mask)));
            @(negedge clk);
            check({tag, "_idle_done"}, 32'(bus.done), 32'd0);
            check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
            check({tag, "_idle_vec"},  32'(bus.vec_out), 32'd0);
            check({tag, "_hold_err"},  32'(bus.err_count), 32'(exp_err));
            check({tag, "_hold_pass"}, 32'(bus.pass), 32'(mask == 16'd0));
            $display("run %s mask=%04h err=%0d pass=%0d first_fail=%0d", tag, mask,
                     bus.err_count, bus.pass, bus.first_fail);
        end else begin
            $display("run %s aborted by reset", tag);
        end
    endtask

    // start held high across two runs.
    task automatic back_to_back(input logic [15:0] mask);
        int done1;
        int done2;
        int busy_low;
        int j;
        done1 = -1;
        done2 = -1;
        busy_low = 0;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k <= 98; k++) begin
            if (bus.done === 1'b1) begin
                if (done1 < 0) done1 = k;
                else if (done2 < 0) done2 = k;
            end
            if (bus.busy !== 1'b1) busy_low++;
            if (k == 98) begin
                check("b2b_pass", 32'(bus.pass), 32'(mask == 16'd0));
                check("b2b_err",  32'(bus.err_count), 32'($countones(mask)));
                bus.start = 1'b0;
            end
            j = (k < 50) ? k : k - 50;
            if (j < LATENCY && (j % PER_VEC) == PER_VEC - 1)
                bus.dut_y = y_for(mask, j / PER_VEC);
            else
                bus.dut_y = 1'($urandom);
            @(negedge clk);
        end
        check("b2b_done1", 32'(done1), 32'd48);
        check("b2b_done2", 32'(done2), 32'd98);
        check("b2b_busy_low", 32'(busy_low), 32'd1);
        repeat (3) @(negedge clk);
        check("b2b_idle_busy", 32'(bus.busy), 32'd0);
        $display("run b2b mask=%04h done1=%0d done2=%0d busy_low=%0d", mask, done1, done2, busy_low);
    endtask

    initial begin
        logic [15:0] m;
        checks    = 0;
        errors    = 0;
        clk       = 1'b0;
        rst_n     = 1'b1;
        bus.start = 1'b0;
        bus.dut_y = 1'b0;

        #3 rst_n = 1'b0;
        #1 check_all_zero("reset_async");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_all_zero("reset_idle");
        $display("reset checked");

        do_run(16'h0000, -1, -1, "golden");
        do_run(16'hFFFF, -1, -1, "stuck0");
        do_run(16'h0220, -1, -1, "sparse");
        do_run(16'h0000, -1, -1, "golden2");
        do_run(16'h0000, 10, -1, "start_ignored");
        back_to_back(16'h0000);
        back_to_back(16'($urandom_range(0, 65535)));
        do_run(16'h0008, -1, 21, "reset_mid");
        do_run(16'h0000, -1, -1, "after_reset");
        for (int r = 0; r < 6; r++) begin
            m = 16'($urandom_range(0, 65535));
            if (r == 0) m = 16'h8000;
            do_run(m, -1, -1, "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
